// File: rtl/lif_integrator.sv
// Leaky integrate-and-fire soma: accumulates synapse weights into an 8-bit
// membrane potential with shift leak, fires on threshold, then goes refractory.
module lif_integrator #(
    parameter int unsigned W1             = 40,
    parameter int unsigned W2             = 25,
    parameter int unsigned THRESHOLD      = 100,
    parameter int unsigned LEAK_SHIFT     = 3,
    parameter int unsigned REFRACT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        spike_in1,
    input  logic        spike_in2,
    output logic        spike,
    output logic [7:0]  potential,
    output logic        refractory,
    output logic [15:0] spike_count
);

    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } state_t;

    localparam logic [9:0] C_W1      = 10'(W1);
    localparam logic [9:0] C_W2      = 10'(W2);
    localparam logic [9:0] C_THRESH  = 10'(THRESHOLD);
    localparam logic [7:0] C_REFRACT = 8'(REFRACT_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_potential;
    logic [7:0]  w_potential_nxt;
    logic        r_spike;
    logic        w_spike_nxt;
    logic [7:0]  r_refract_cnt;
    logic [7:0]  w_refract_cnt_nxt;
    logic [15:0] r_spike_count;
    logic [15:0] w_spike_count_nxt;

    logic [9:0]  w_leak;
    logic [9:0]  w_gain;
    logic [9:0]  w_sum;
    logic [7:0]  w_sum_sat;
    logic        w_fire;

    // 10-bit datapath: worst case 255 + 255 + 255 still fits before saturation.
    always_comb begin
        w_leak    = {2'b00, r_potential >> LEAK_SHIFT};
        w_gain    = (spike_in1 ? C_W1 : '0) + (spike_in2 ? C_W2 : '0);
        w_sum     = {2'b00, r_potential} - w_leak + w_gain;
        w_sum_sat = (w_sum > 10'd255) ? 8'hFF : w_sum[7:0];
        w_fire    = ({2'b00, w_sum_sat} >= C_THRESH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_INTEGRATE;
            r_potential   <= '0;
            r_spike       <= 1'b0;
            r_refract_cnt <= '0;
            r_spike_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_potential   <= w_potential_nxt;
            r_spike       <= w_spike_nxt;
            r_refract_cnt <= w_refract_cnt_nxt;
            r_spike_count <= w_spike_count_nxt;
        end
    end

    // Disabled edges hold everything; only the spike pulse is cleared.
    always_comb begin
        w_state_nxt       = r_state;
        w_potential_nxt   = r_potential;
        w_spike_nxt       = 1'b0;
        w_refract_cnt_nxt = r_refract_cnt;
        w_spike_count_nxt = r_spike_count;
        if (enable) begin
            case (r_state)
                ST_INTEGRATE: begin
                    if (w_fire) begin
                        w_spike_nxt       = 1'b1;
                        w_potential_nxt   = '0;
                        w_spike_count_nxt = r_spike_count + 16'd1;
                        w_refract_cnt_nxt = C_REFRACT;
                        w_state_nxt       = (C_REFRACT != 8'd0) ? ST_REFRACTORY : ST_INTEGRATE;
                    end else begin
                        w_potential_nxt = w_sum_sat;
                    end
                end
                ST_REFRACTORY: begin
                    w_potential_nxt = '0;
                    if (r_refract_cnt <= 8'd1) begin
                        w_refract_cnt_nxt = '0;
                        w_state_nxt       = ST_INTEGRATE;
                    end else begin
                        w_refract_cnt_nxt = r_refract_cnt - 8'd1;
                    end
                end
                default: w_state_nxt = ST_INTEGRATE;
            endcase
        end
    end

    assign spike       = r_spike;
    assign potential   = r_potential;
    assign refractory  = (r_state == ST_REFRACTORY);
    assign spike_count = r_spike_count;

endmodule

// File: tb/tb_lif_integrator.sv
// Bench for lif_integrator: directed vector table, hand-written corner
// sequences, and randomized stimulus against a behavioural neuron model.
module tb_lif_integrator;

    logic clk = 1'b0;
    logic reset, enable, spike_in1, spike_in2;

    logic        a_spike, b_spike, c_spike;
    logic [7:0]  a_pot, b_pot, c_pot;
    logic        a_refr, b_refr, c_refr;
    logic [15:0] a_cnt, b_cnt, c_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    lif_integrator dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .spike_in1(spike_in1), .spike_in2(spike_in2),
        .spike(a_spike), .potential(a_pot), .refractory(a_refr), .spike_count(a_cnt)
    );

    lif_integrator #(.W1(200), .W2(200), .THRESHOLD(255)) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .spike_in1(spike_in1), .spike_in2(spike_in2),
        .spike(b_spike), .potential(b_pot), .refractory(b_refr), .spike_count(b_cnt)
    );

    lif_integrator #(.W1(120), .REFRACT_CYCLES(0)) dut_c (
        .clk(clk), .reset(reset), .enable(enable),
        .spike_in1(spike_in1), .spike_in2(spike_in2),
        .spike(c_spike), .potential(c_pot), .refractory(c_refr), .spike_count(c_cnt)
    );

    typedef struct {
        bit rst; bit en; bit a; bit b;
        bit spk; int pot; bit refr; int cnt;
    } vec_t;

    // Model tracks "refractory edges still owed" rather than an FSM state.
    typedef struct {
        int pot; int left; int cnt; bit spk;
    } neuron_t;

    typedef struct {
        int w1; int w2; int th; int ls; int rc;
    } cfg_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic vec_t V(bit rst, bit en, bit a, bit b, bit spk, int pot, bit refr, int cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.a = a; v.b = b;
        v.spk = spk; v.pot = pot; v.refr = refr; v.cnt = cnt;
        return v;
    endfunction

    function automatic neuron_t mstep(neuron_t m, bit en, bit a, bit b, cfg_t c);
        neuron_t n = m;
        int s;
        n.spk = 1'b0;
        if (!en) return n;
        if (m.left > 0) begin
            n.left = m.left - 1;
            n.pot  = 0;
        end else begin
            s = m.pot - m.pot / (2 ** c.ls) + (a ? c.w1 : 0) + (b ? c.w2 : 0);
            if (s > 255) s = 255;
            if (s >= c.th) begin
                n.spk  = 1'b1;
                n.pot  = 0;
                n.cnt  = (m.cnt + 1) % 65536;
                n.left = c.rc;
            end else begin
                n.pot = s;
            end
        end
        return n;
    endfunction

    task automatic chk_model(input string tag, input neuron_t m,
                             input logic spk, input logic [7:0] pot,
                             input logic refr, input logic [15:0] cnt);
        chk({tag, ".spike"}, 32'(spk), 32'(m.spk));
        chk({tag, ".pot"}, 32'(pot), 32'(m.pot));
        chk({tag, ".refr"}, 32'(refr), 32'(m.left > 0));
        chk({tag, ".cnt"}, 32'(cnt), 32'(m.cnt));
    endtask

    initial begin
        vec_t    vecs[$];
        neuron_t ma, mb, mc;
        cfg_t    ca, cb, cc;
        int      decay[14] = '{25, 22, 20, 18, 16, 14, 13, 12, 11, 10, 9, 8, 7, 7};

        reset = 1'b1; enable = 1'b1; spike_in1 = 1'b0; spike_in2 = 1'b0;

        // reset held with inputs toggling
        vecs.push_back(V(1, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(V(1, 1, 0, 1, 0, 0, 0, 0));
        // spike_in1 held high: 40, 75, fire on 106, 4 refractory edges, then 40
        vecs.push_back(V(0, 1, 1, 0, 0, 40, 0, 0));
        vecs.push_back(V(0, 1, 1, 0, 0, 75, 0, 0));
        vecs.push_back(V(0, 1, 1, 0, 1, 0, 1, 1));
        vecs.push_back(V(0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(V(0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(V(0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(V(0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(V(0, 1, 1, 0, 0, 40, 0, 1));
        // both inputs high: 65, then fire on 122
        vecs.push_back(V(1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(V(0, 1, 1, 1, 0, 65, 0, 0));
        vecs.push_back(V(0, 1, 1, 1, 1, 0, 1, 1));
        vecs.push_back(V(0, 1, 1, 1, 0, 0, 1, 1));
        vecs.push_back(V(0, 1, 1, 1, 0, 0, 1, 1));
        vecs.push_back(V(0, 1, 1, 1, 0, 0, 1, 1));
        vecs.push_back(V(0, 1, 1, 1, 0, 0, 0, 1));
        vecs.push_back(V(0, 1, 1, 1, 0, 65, 0, 1));
        // single spike_in2 pulse then leak down to the floor
        vecs.push_back(V(1, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 14; i++)
            vecs.push_back(V(0, 1, 0, (i == 0), 0, decay[i], 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; enable = vecs[i].en;
            spike_in1 = vecs[i].a; spike_in2 = vecs[i].b;
            tick();
            chk($sformatf("vec%0d.spike", i), 32'(a_spike), 32'(vecs[i].spk));
            chk($sformatf("vec%0d.pot", i), 32'(a_pot), 32'(vecs[i].pot));
            chk($sformatf("vec%0d.refr", i), 32'(a_refr), 32'(vecs[i].refr));
            chk($sformatf("vec%0d.cnt", i), 32'(a_cnt), 32'(vecs[i].cnt));
        end

        // asynchronous reset mid-refractory
        spike_in1 = 1'b0; spike_in2 = 1'b0;
        do_reset();
        spike_in1 = 1'b1;
        repeat (4) tick();
        chk("midref.refr_before", 32'(a_refr), 32'd1);
        chk("midref.cnt_before", 32'(a_cnt), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("midref.refr_async", 32'(a_refr), 32'd0);
        chk("midref.cnt_async", 32'(a_cnt), 32'd0);
        chk("midref.pot_async", 32'(a_pot), 32'd0);
        tick();
        reset = 1'b0;

        // enable low right after a fire freezes the refractory period
        do_reset();
        spike_in1 = 1'b1;
        repeat (3) tick();
        chk("freeze.fire", 32'(a_spike), 32'd1);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("freeze%0d.spike", i), 32'(a_spike), 32'd0);
            chk($sformatf("freeze%0d.refr", i), 32'(a_refr), 32'd1);
            chk($sformatf("freeze%0d.pot", i), 32'(a_pot), 32'd0);
            chk($sformatf("freeze%0d.cnt", i), 32'(a_cnt), 32'd1);
        end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("resume%0d.refr", i), 32'(a_refr), 32'(i < 3));
            chk($sformatf("resume%0d.spike", i), 32'(a_spike), 32'd0);
        end
        tick();
        chk("resume.pot", 32'(a_pot), 32'd40);

        // saturation and zero-refractory back-to-back firing
        do_reset();
        spike_in1 = 1'b1; spike_in2 = 1'b1;
        tick();
        chk("sat.spike", 32'(b_spike), 32'd1);
        chk("sat.cnt", 32'(b_cnt), 32'd1);
        chk("sat.pot", 32'(b_pot), 32'd0);
        do_reset();
        spike_in2 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("r0_%0d.spike", i), 32'(c_spike), 32'd1);
            chk($sformatf("r0_%0d.refr", i), 32'(c_refr), 32'd0);
            chk($sformatf("r0_%0d.cnt", i), 32'(c_cnt), 32'(i));
        end

        // randomized run against the behavioural model, all three configurations
        ca = '{w1: 40, w2: 25, th: 100, ls: 3, rc: 4};
        cb = '{w1: 200, w2: 200, th: 255, ls: 3, rc: 4};
        cc = '{w1: 120, w2: 25, th: 100, ls: 3, rc: 0};
        do_reset();
        ma = '{pot: 0, left: 0, cnt: 0, spk: 0};
        mb = ma; mc = ma;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset     = ($urandom_range(0, 199) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            spike_in1 = ($urandom_range(0, 3) == 0);
            spike_in2 = ($urandom_range(0, 2) == 0);
            tick();
            if (reset) begin
                ma = '{pot: 0, left: 0, cnt: 0, spk: 0};
                mb = ma; mc = ma;
            end else begin
                ma = mstep(ma, enable, spike_in1, spike_in2, ca);
                mb = mstep(mb, enable, spike_in1, spike_in2, cb);
                mc = mstep(mc, enable, spike_in1, spike_in2, cc);
            end
            chk_model($sformatf("rnd%0d.a", cyc), ma, a_spike, a_pot, a_refr, a_cnt);
            chk_model($sformatf("rnd%0d.b", cyc), mb, b_spike, b_pot, b_refr, b_cnt);
            chk_model($sformatf("rnd%0d.c", cyc), mc, c_spike, c_pot, c_refr, c_cnt);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
